// File: rtl/decoder_3_8_stream.sv
// decoder_3_8_stream
//   Registered binary-to-one-hot decoder with valid/ready handshakes on both
//   sides. A main output register and one skid register give a capacity of
//   two entries, so the block sustains one entry per cycle and absorbs a
//   downstream stall without dropping data. In scan mode an internal counter
//   generates codes 0..OUT_W-1 cyclically in place of the input port.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A/en valid this cycle
//   in_ready   block accepts an input this cycle
//   A          binary code to decode
//   en         decode enable; 0 yields an all-zero Y (code_out still = A)
//   scan_en    1 = internal code generator replaces the input port
//   out_valid  Y/code_out valid
//   out_ready  downstream accepts Y
//   Y          one-hot decoded value (zero when en was 0)
//   code_out   binary code that produced Y
module decoder_3_8_stream #(
  parameter  int IN_W  = 3,
  localparam int OUT_W = 1 << IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  A,
  input  logic             en,
  input  logic             scan_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] Y,
  output logic [IN_W-1:0]  code_out
);

  // Main (output) register
  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_y_q, main_y_d;
  logic [IN_W-1:0]  main_code_q, main_code_d;

  // Skid register
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_y_q, skid_y_d;
  logic [IN_W-1:0]  skid_code_q, skid_code_d;

  // Scan generator state
  logic [IN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic             scan_en_q;

  // Entry presented to the storage this cycle (port or generator)
  logic             scan_rise;
  logic             gen_fire;
  logic             in_fire;
  logic             push;
  logic             pop;
  logic [IN_W-1:0]  scan_code;
  logic [IN_W-1:0]  push_code;
  logic             push_en;
  logic [OUT_W-1:0] push_y;

  // Acceptance only depends on registered state and the mode input.
  assign in_ready = rst_n & ~skid_valid_q & ~scan_en;

  // A fresh entry into scan mode starts at code 0 in that very cycle; the
  // stored counter is bypassed so no stale count leaks out.
  assign scan_rise = scan_en & ~scan_en_q;
  assign scan_code = scan_rise ? '0 : scan_cnt_q;
  assign gen_fire  = rst_n & scan_en & ~skid_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign push      = in_fire | gen_fire;
  assign push_code = scan_en ? scan_code : A;
  assign push_en   = scan_en | en;
  assign pop       = main_valid_q & out_ready;

  // One-hot decode of the incoming entry
  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
    assign push_y[gi] = push_en & (push_code == IN_W'(gi));
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_y_d     = main_y_q;
    main_code_d  = main_code_q;
    skid_valid_d = skid_valid_q;
    skid_y_d     = skid_y_q;
    skid_code_d  = skid_code_q;
    scan_cnt_d   = scan_cnt_q;

    if (!main_valid_q || pop) begin
      // Main is free at this edge: the oldest entry moves in. A push cannot
      // coincide with a full skid because both paths require it empty.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_y_d     = skid_y_q;
        main_code_d  = skid_code_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_valid_d = 1'b1;
        main_y_d     = push_y;
        main_code_d  = push_code;
      end else begin
        // Y/code_out keep their last value while empty.
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      // Main stalled: park the new entry in the skid register.
      skid_valid_d = 1'b1;
      skid_y_d     = push_y;
      skid_code_d  = push_code;
    end

    // Width IN_W wraps naturally from OUT_W-1 to 0.
    if (gen_fire) begin
      scan_cnt_d = scan_code + IN_W'(1);
    end else if (scan_rise) begin
      scan_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_y_q     <= '0;
      main_code_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_y_q     <= '0;
      skid_code_q  <= '0;
      scan_cnt_q   <= '0;
      scan_en_q    <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_y_q     <= main_y_d;
      main_code_q  <= main_code_d;
      skid_valid_q <= skid_valid_d;
      skid_y_q     <= skid_y_d;
      skid_code_q  <= skid_code_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_en_q    <= scan_en;
    end
  end

  assign out_valid = main_valid_q;
  assign Y         = main_y_q;
  assign code_out  = main_code_q;

endmodule

// File: tb/tb_decoder_3_8_stream.sv
// Directed testbench for decoder_3_8_stream. Inputs change and outputs are
// sampled on the falling clock edge; every transfer happens on the rising edge.
module tb_decoder_3_8_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] A;
  logic       en;
  logic       scan_en;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic [2:0] code_out;

  int n_cmp;
  int n_err;

  decoder_3_8_stream #(.IN_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .en       (en),
    .scan_en  (scan_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .code_out (code_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written one-hot table for codes 0..7
  logic [7:0] onehot [8];
  initial begin
    onehot[0] = 8'h01; onehot[1] = 8'h02; onehot[2] = 8'h04; onehot[3] = 8'h08;
    onehot[4] = 8'h10; onehot[5] = 8'h20; onehot[6] = 8'h40; onehot[7] = 8'h80;
  end

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; A = '0; en = 1'b0; scan_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 8'h00 || code_out !== 3'd0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset: out_valid=%b Y=%h code=%0d in_ready=%b, required 0/00/0/0",
               out_valid, Y, code_out, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    $display("reset: done");
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        n_cmp++;
        if (out_valid !== 1'b1 || Y !== onehot[i-1] || code_out !== 3'(i-1)) begin
          n_err++;
          $display("FAIL stream[%0d]: valid=%b Y=%h code=%0d, required 1/%h/%0d",
                   i-1, out_valid, Y, code_out, onehot[i-1], i-1);
        end else begin
          $display("stream: code %0d -> Y=%h", code_out, Y);
        end
      end
      if (i < 8) begin
        in_valid = 1'b1; A = 3'(i); en = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL stream_in_ready[%0d]: got %b required 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_en_zero();
    out_ready = 1'b0;
    in_valid = 1'b1; A = 3'd3; en = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; en = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 8'h00 || code_out !== 3'd3) begin
      n_err++;
      $display("FAIL en_zero: valid=%b Y=%h code=%0d, required 1/00/3", out_valid, Y, code_out);
    end else begin
      $display("en_zero: code 3 -> Y=%h", Y);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL en_zero_once: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; A = 3'd5; en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || Y !== 8'h20) begin
      n_err++;
      $display("FAIL bp_first: in_ready=%b Y=%h, required 1/20", in_ready, Y);
    end
    A = 3'd6;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || Y !== 8'h20 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_full: in_ready=%b Y=%h valid=%b, required 0/20/1", in_ready, Y, out_valid);
    end
    A = 3'd7;  // offered while stalled
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || Y !== 8'h20 || code_out !== 3'd5) begin
      n_err++;
      $display("FAIL bp_hold: in_ready=%b Y=%h code=%0d, required 0/20/5", in_ready, Y, code_out);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (Y !== 8'h40 || code_out !== 3'd6 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second: Y=%h code=%0d in_ready=%b, required 40/6/1", Y, code_out, in_ready);
    end else begin
      $display("back_to_back: code 6 -> Y=%h", Y);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (Y !== 8'h80 || code_out !== 3'd7 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_third: Y=%h code=%0d valid=%b, required 80/7/1", Y, code_out, out_valid);
    end else begin
      $display("back_to_back: code 7 -> Y=%h", Y);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: out_valid=%b required 0 (extra entry)", out_valid);
    end
  endtask

  // Runs scan with out_ready=1 and checks n codes starting from 0.
  task automatic scan_run(input int n, input string tag);
    out_ready = 1'b1; in_valid = 1'b1; A = 3'd6; en = 1'b0;  // port must be ignored
    scan_en = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_in_ready: got %b required 0", tag, in_ready);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || code_out !== 3'(k % 8) || Y !== onehot[k % 8]) begin
        n_err++;
        $display("FAIL %s[%0d]: valid=%b code=%0d Y=%h, required 1/%0d/%h",
                 tag, k, out_valid, code_out, Y, k % 8, onehot[k % 8]);
      end else begin
        $display("%s: code %0d -> Y=%h", tag, code_out, Y);
      end
    end
    scan_en = 1'b0; in_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stop: out_valid=%b required 0", tag, out_valid);
    end
  endtask

  task automatic test_scan();
    scan_run(10, "scan");
    scan_run(3, "scan_restart");
  endtask

  task automatic test_scan_random();
    int exp_code;
    int drained;
    exp_code = 0;
    in_valid = 1'b0;
    scan_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        n_cmp++;
        if (code_out !== 3'(exp_code % 8) || Y !== onehot[exp_code % 8]) begin
          n_err++;
          $display("FAIL scan_rand[%0d]: code=%0d Y=%h, required %0d/%h",
                   exp_code, code_out, Y, exp_code % 8, onehot[exp_code % 8]);
        end else begin
          $display("scan_rand: code %0d -> Y=%h", code_out, Y);
        end
        exp_code++;
      end
      @(negedge clk);
    end
    // Stop generation; buffered entries must drain in sequence.
    scan_en = 1'b0; out_ready = 1'b1;
    drained = 0;
    while (out_valid && drained < 4) begin
      n_cmp++;
      if (code_out !== 3'(exp_code % 8)) begin
        n_err++;
        $display("FAIL scan_drain[%0d]: code=%0d required %0d", exp_code, code_out, exp_code % 8);
      end
      exp_code++; drained++;
      @(negedge clk);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || exp_code < 5) begin
      n_err++;
      $display("FAIL scan_drain_end: out_valid=%b transfers=%0d, required 0 and >=5",
               out_valid, exp_code);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; en = 1'b1; A = 3'd1;
    @(negedge clk);
    A = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_full: in_ready=%b valid=%b, required 0/1", in_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || Y !== 8'h00 || code_out !== 3'd0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: valid=%b Y=%h code=%0d in_ready=%b, required 0/00/0/0",
               out_valid, Y, code_out, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; A = 3'd2;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || Y !== 8'h04 || code_out !== 3'd2) begin
      n_err++;
      $display("FAIL rst_mid_first: valid=%b Y=%h code=%0d, required 1/04/2", out_valid, Y, code_out);
    end else begin
      $display("reset_mid: code 2 -> Y=%h", Y);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_stale: out_valid=%b code=%0d, required 0", out_valid, code_out);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_en_zero();
    test_back_to_back();
    test_scan();
    test_scan_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
